dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port: a word-organised RAM that accepts one request at a time, waits a programmable latency, then returns a response.
- Uses a valid/ready request and response handshake, so the CPU or a D$ controller can be verified against a multi-cycle memory.
- Sits between the core's load/store path and backing storage, replacing the single-cycle data memory.

Parameters:
- ADDR_W, 12, byte-address bits decoded; word index = req_addr[ADDR_W-1:2]; upper address bits ignored.
- LATENCY, 2, cycles from accept edge to response; legal range 1..15.
- DEPTH, 1 << (ADDR_W-2), words of storage; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; bit i covers bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes response.
- resp_rdata  out  32  read data; 0 for writes.
- resp_err  out  1  access error (optional feature only).

Behaviour:
- One clock, clk; reset rst is asynchronous, active-high.
- While rst=1: state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Storage contents are not reset.
- req_ready=1 exactly when state=IDLE and rst=0.
- States:
  - IDLE: req_valid & req_ready at an edge = accept. Latch wr, word index, wdata, be. If LATENCY=1, commit the access at this edge and go to RESP. Else load cnt=LATENCY-2 and go to WAIT.
  - WAIT: req_ready=0. cnt decrements each edge. At the edge where cnt=0, commit the access and go to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_valid & resp_ready at an edge, then go to IDLE.
- Timing: resp_valid is first high in the cycle following the LATENCY-th rising edge, counting the accept edge as edge 1.
- Minimum spacing between accepts is LATENCY+1 cycles; there is no pipelining.
- Commit, write: each byte i with be[i]=1 is updated; other bytes are unchanged. resp_rdata=0.
- Commit, read: resp_rdata = the full stored word; req_be is ignored for reads.
- Read-after-write to the same word returns the new data.
- req_valid while req_ready=0 is ignored; the requester must hold the request until accepted.
- Address wrap: bits above ADDR_W-1 are ignored, so addresses alias modulo DEPTH words.
- Reset mid-operation: the in-flight transaction is dropped. A write not yet committed must not modify storage; a write already committed remains.
- be=0 write: completes normally and storage is unchanged.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - An accepted request with req_addr[1:0]≠0 is an error. It performs no storage access and still follows the full LATENCY timing.
  - Its response has resp_err=1 and resp_rdata=0.
  - Aligned requests have resp_err=0.
- Undefined:
  - req_addr[1:0] is ignored and the access proceeds on the word.
  - resp_err is tied to 0.

Decomposition:
- Shared package dmem_pkg holds:
  - state typedef {IDLE, WAIT, RESP};
  - WORD_W=32, BE_W=4, BE_ALL=4'hF;
  - DEFAULT_LATENCY=2.
- Sub-module dmem_array: DEPTH×32 storage with per-byte write enable and synchronous read. Addressed by the word index at commit.
- FSM, counter and handshake stay in dmem_responder.

Test Plan:
1. Reset during a write: accept write 0xA5A5A5A5 @0x20 (LATENCY=3), assert rst in WAIT → resp_valid=0 and req_ready=0 while rst=1. Then read @0x20 → prior value (0x0 after preload).
2. Write then read: write 0xDEADBEEF @0x10 be=F → resp_valid high in the cycle after the 2nd edge (LATENCY=2), rdata=0. Then read @0x10 → 0xDEADBEEF.
3. Byte enables: write 0x11223344 @0x10 be=4'b0101 over 0xDEADBEEF → read returns 0xDE22BE44.
4. Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 → resp_valid, rdata and err stay stable, req_ready=0, and no second accept occurs. Raising resp_ready gives a handshake, then req_ready=1 the next cycle.
5. Wrap and LATENCY=1: write 0xCAFEF00D @0x1004 → resp_valid in the cycle after the accept edge. Read @0x0004 → 0xCAFEF00D.
6. Feature: read/write @0x13 with DMEM_ALIGN_CHECK_EN → resp_err=1, rdata=0, word @0x10 unchanged. Without the macro → write updates @0x10 and resp_err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

    localparam int WORD_W          = 32;
    localparam int BE_W            = 4;
    localparam logic [BE_W-1:0] BE_ALL = 4'hF;
    localparam int DEFAULT_LATENCY = 2;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

    // Expand per-byte enables into a per-bit mask.
    function automatic logic [WORD_W-1:0] be_mask(input logic [BE_W-1:0] be);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enable and a registered read port.
// Contents are never reset; the read register only updates when re_i is high.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << IDX_W;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= (mem_q[idx_i] & ~be_mask(be_i)) | (wdata_i & be_mask(be_i));
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable access latency.
// Optional misaligned-access error reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int CNT_W = 4;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              err_q, err_d;

    logic              accept;
    logic              req_err;
    logic              commit;
    logic              arr_we;
    logic              arr_re;
    logic [WORD_W-1:0] arr_rdata;
    logic              unused_addr;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == RESP);

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    assign unused_addr = ^{req_addr[31:ADDR_W], req_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = req_wr;
                    idx_d   = req_addr[ADDR_W-1:2];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = req_err;
                    if (LATENCY == 1) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 2);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The *_d fields carry the live request at a latency-1 accept and the latched one otherwise.
    assign arr_we = commit && wr_d && !err_d;
    assign arr_re = commit && !wr_d && !err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .idx_i   (idx_d),
        .wdata_i (wdata_d),
        .be_i    (be_d),
        .rdata_o (arr_rdata)
    );

    assign resp_rdata = (resp_valid && !wr_q && !err_q) ? arr_rdata : '0;

`ifdef DMEM_ALIGN_CHECK_EN
    assign resp_err = resp_valid && err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Drives three responders (LATENCY 1, 2, 3) and checks them every cycle against a transaction-level model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int ND = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [ND-1:0]     req_valid, req_wr, req_ready, resp_valid, resp_ready, resp_err;
    logic [31:0]       req_addr   [ND];
    logic [31:0]       req_wdata  [ND];
    logic [31:0]       resp_rdata [ND];
    logic [3:0]        req_be     [ND];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dmem_responder #(.ADDR_W(12), .LATENCY(g + 1)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_wr     (req_wr[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_be     (req_be[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    // Transaction-level model: one outstanding request, commit LATENCY-1 edges after accept.
    bit          m_busy  [ND];
    bit          m_comm  [ND];
    int          m_wait  [ND];
    bit          m_wr    [ND];
    bit [31:0]   m_addr  [ND];
    bit [31:0]   m_wdata [ND];
    bit [3:0]    m_be    [ND];
    bit [31:0]   m_rdata [ND];
    bit          m_err   [ND];
    bit [31:0]   m_mem   [ND][1024];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_commit(input int d);
        int idx;
        idx = int'(m_addr[d] >> 2) % 1024;
`ifdef DMEM_ALIGN_CHECK_EN
        m_err[d] = (m_addr[d] % 4) != 0;
`else
        m_err[d] = 1'b0;
`endif
        m_rdata[d] = 32'h0;
        if (!m_err[d]) begin
            if (m_wr[d]) begin
                for (int i = 0; i < 4; i++)
                    if (m_be[d][i]) m_mem[d][idx][8*i +: 8] = m_wdata[d][8*i +: 8];
            end else begin
                m_rdata[d] = m_mem[d][idx];
            end
        end
        m_comm[d] = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                m_busy[d] = 1'b0;
                m_comm[d] = 1'b0;
            end else if (!m_busy[d]) begin
                if (req_valid[d]) begin
                    m_busy[d]  = 1'b1;
                    m_comm[d]  = 1'b0;
                    m_wr[d]    = req_wr[d];
                    m_addr[d]  = req_addr[d];
                    m_wdata[d] = req_wdata[d];
                    m_be[d]    = req_be[d];
                    m_wait[d]  = d;
                    if (m_wait[d] == 0) model_commit(d);
                end
            end else if (!m_comm[d]) begin
                m_wait[d]--;
                if (m_wait[d] == 0) model_commit(d);
            end else if (resp_ready[d]) begin
                m_busy[d] = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d.req_ready", d), 32'(req_ready[d]), 32'(!rst && !m_busy[d]));
            chk($sformatf("d%0d.resp_valid", d), 32'(resp_valid[d]), 32'(!rst && m_busy[d] && m_comm[d]));
            if (rst) begin
                chk($sformatf("d%0d.rst_rdata", d), resp_rdata[d], 32'h0);
                chk($sformatf("d%0d.rst_err", d), 32'(resp_err[d]), 32'h0);
            end else if (m_busy[d] && m_comm[d]) begin
                chk($sformatf("d%0d.resp_rdata", d), resp_rdata[d], m_rdata[d]);
                chk($sformatf("d%0d.resp_err", d), 32'(resp_err[d]), 32'(m_err[d]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic txn(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input bit keep_valid,
                       output logic [31:0] rdata, output logic err, output int lat);
        int k;
        req_valid[d] = 1'b1;
        req_wr[d]    = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        k = 0;
        while (!req_ready[d] && k < 100) begin step(); k++; end
        if (k >= 100) chk($sformatf("d%0d.accept_timeout", d), 32'(k), 32'h0);
        step();
        if (!keep_valid) req_valid[d] = 1'b0;
        lat = 1;
        k = 0;
        while (!resp_valid[d] && k < 100) begin step(); lat++; k++; end
        if (k >= 100) chk($sformatf("d%0d.resp_timeout", d), 32'(k), 32'h0);
        rdata = resp_rdata[d];
        err   = resp_err[d];
        repeat (hold) step();
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        step();
        resp_ready[d] = 1'b0;
    endtask

    task automatic rand_loop(input int d);
        logic [31:0] rd;
        logic        er;
        int          lat;
        repeat (60) begin
            repeat ($urandom_range(0, 2)) step();
            txn(d, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_F03F, $urandom(),
                4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0, rd, er, lat);
            chk($sformatf("d%0d.rand_latency", d), 32'(lat), 32'(d + 1));
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        rst = 1'b1;
        req_valid = '0; req_wr = '0; resp_ready = '0;
        for (int d = 0; d < ND; d++) begin
            req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();

        // Bring the words used by the bench to a known zero value.
        for (int d = 0; d < ND; d++)
            for (int w = 0; w < 16; w++)
                txn(d, 1'b1, 32'(w * 4), 32'h0, BE_ALL, 0, 1'b0, rd, er, lat);

        // Reset lands while a LATENCY=3 write is still waiting.
        req_valid[2] = 1'b1; req_wr[2] = 1'b1; req_addr[2] = 32'h20;
        req_wdata[2] = 32'hA5A5_A5A5; req_be[2] = BE_ALL;
        step();
        req_valid[2] = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_mid.req_ready", 32'(req_ready[2]), 32'h0);
        chk("rst_mid.resp_valid", 32'(resp_valid[2]), 32'h0);
        step();
        rst = 1'b0;
        step();
        txn(2, 1'b0, 32'h20, 32'h0, BE_ALL, 0, 1'b0, rd, er, lat);
        chk("rst_mid.read", rd, 32'h0);
        chk("rst_mid.read_lat", 32'(lat), 32'd3);

        txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, BE_ALL, 0, 1'b0, rd, er, lat);
        chk("wr.latency", 32'(lat), 32'd2);
        chk("wr.rdata", rd, 32'h0);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("rd.rdata", rd, 32'hDEAD_BEEF);

        txn(1, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, 1'b0, rd, er, lat);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("be.rdata", rd, 32'hDE22_BE44);

        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, rd, er, lat);
        chk("bp.rdata", rd, 32'hDE22_BE44);
        chk("bp.ready_after", 32'(req_ready[1]), 32'h1);

        txn(0, 1'b1, 32'h1004, 32'hCAFE_F00D, BE_ALL, 0, 1'b0, rd, er, lat);
        chk("wrap.latency", 32'(lat), 32'd1);
        txn(0, 1'b0, 32'h0004, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("wrap.rdata", rd, 32'hCAFE_F00D);

        txn(1, 1'b1, 32'h13, 32'h5566_7788, BE_ALL, 0, 1'b0, rd, er, lat);
        chk("mis_wr.rdata", rd, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_wr.err", 32'(er), 32'h1);
        txn(1, 1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("mis_rd.err", 32'(er), 32'h1);
        chk("mis_rd.rdata", rd, 32'h0);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("mis_word.rdata", rd, 32'hDE22_BE44);
`else
        chk("mis_wr.err", 32'(er), 32'h0);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("mis_word.rdata", rd, 32'h5566_7788);
        chk("mis_word.err", 32'(er), 32'h0);
`endif

        fork
            rand_loop(0);
            rand_loop(1);
            rand_loop(2);
        join

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
